seq_state_monitor: RTL and testbench
====================================

Name: seq_state_monitor

Overview:
- Downstream checker for the 2-bit T-flip-flop sequencer output. Legal cycle: 00 -> 01 -> 10 -> 00; code 11 is illegal.
- Samples the state code on enabled cycles and predicts the next code. Hunts for, acquires and holds lock on the sequence.
- Counts completed sequence periods and transition errors, and flags illegal codes.
- Sits between the sequencer and the status/debug register bank.

Parameters:
- CNT_W, 8: width of period_cnt and err_cnt.
- LOCK_LEN, 3: consecutive correct transitions needed to enter LOCKED (legal range 1..15).
- UNLOCK_LEN, 2: consecutive mismatches in LOCKED that drop lock (legal range 1..15).

Ports:
- clk  input  1  clock, rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  sample enable; state_in is evaluated only when en=1.
- state_in  input  2  sequencer state code {A,B}.
- clr  input  1  synchronous clear of period_cnt, err_cnt and stuck.
- locked  output  1  registered; 1 while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on each counted mismatch.
- illegal  output  1  one-cycle pulse when an enabled sample equals 11.
- period_cnt  output  CNT_W  completed periods while locked; wraps.
- err_cnt  output  CNT_W  mismatch count; saturates at all-ones.
- stuck  output  1  sticky stuck flag (see Optional Feature).

Behaviour:
- Reset (async, rstn=0):
  - FSM = HUNT; prev = 00; match_run = 0; miss_run = 0.
  - All outputs = 0.
- Prediction function nxt(p): 00->01, 01->10, 10->00, 11->none. Any sample compared against nxt(11) is a mismatch.
- Timing:
  - All outputs are registered; effects are visible the cycle after the sampling edge.
  - err_pulse and illegal are 0 on every cycle where the qualifying event did not occur, including every en=0 cycle.
- prev update: prev <= state_in on every en=1 cycle, in every state.
- en=0: FSM, run counters, prev and counters hold. clr is still honoured.
- FSM, per en=1 sample:
  - HUNT:
    - state_in=11: illegal=1, stay in HUNT.
    - Otherwise: go to SYNC, match_run=0.
    - No err_cnt change in HUNT.
  - SYNC:
    - state_in=11: illegal=1, err_pulse=1, err_cnt+1, go to HUNT.
    - Match: match_run+1. When match_run reaches LOCK_LEN, go to LOCKED with miss_run=0.
    - Mismatch (not 11): err_pulse=1, err_cnt+1, match_run=0, stay in SYNC.
  - LOCKED:
    - Match: miss_run=0. If prev=10 and state_in=00, period_cnt+1 (wraps).
    - Mismatch (not 11): err_pulse=1, err_cnt+1, miss_run+1. When miss_run reaches UNLOCK_LEN, go to SYNC with match_run=0.
    - state_in=11: illegal=1, err_pulse=1, err_cnt+1, go to HUNT.
- Counter rules:
  - err_cnt saturates at 2^CNT_W-1; err_pulse still fires when saturated.
  - clr in the same cycle as an increment: clr wins, counter = 0.
  - clr does not affect the FSM, prev or the run counters.
- Reset mid-operation: immediate return to the reset state. Counts are lost.

Optional Feature:
- Macro: SEQ_STATE_MONITOR_STUCK_EN.
- Defined:
  - A 2-bit hold counter increments on each en=1 sample equal to prev and clears on any change.
  - On the 4th consecutive identical sample (hold count 3 -> 4th), stuck <= 1.
  - stuck is sticky until clr or reset.
  - Hold samples are still treated as normal mismatches by the FSM.
- Not defined: no hold counter; the stuck port remains and is tied to 0.

Test Plan:
- Lock and period count: reset; en=1; drive 00,01,10,00 -> locked=1 after the 4th sample. Continue 01,10,00 -> period_cnt=1, err_cnt=0, no err_pulse.
- Single mismatch: while locked, drive 00 then 10 -> err_pulse exactly 1 cycle, err_cnt=1, locked stays 1. Next sample 00 -> match, miss_run cleared.
- Lock loss: while locked, drive two consecutive wrong codes (after 01: 01, then 00) -> err_cnt=2, locked=0. Then drive 01,10,00 -> locked=1 again.
- Illegal code: while locked, drive 11 -> illegal=1 and err_pulse=1 for 1 cycle, err_cnt+1, locked=0, FSM in HUNT. Next legal sample -> SYNC.
- Saturation and clr (CNT_W=4): from SYNC, drive 00 for 20 samples -> err_cnt=15 and holds. Pulse clr in the same cycle as a mismatch -> err_cnt=0. With SEQ_STATE_MONITOR_STUCK_EN defined, stuck=1 is set, then cleared by clr.
- en gating and async reset: en=0 with random state_in for 10 cycles -> no output changes. Deassert rstn mid-lock, asynchronously between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/seq_state_monitor.sv
// seq_state_monitor: checks the 2-bit sequencer code (00 -> 01 -> 10 -> 00), tracks lock,
// counts periods and errors. Stuck-code detector enabled by SEQ_STATE_MONITOR_STUCK_EN.
module seq_state_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_LEN   = 3,
    parameter int unsigned UNLOCK_LEN = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       state_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             illegal,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stuck
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_THR   = 4'(LOCK_LEN);
    localparam logic [3:0] UNLOCK_THR = 4'(UNLOCK_LEN);

    logic [1:0]       state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [3:0]       miss_run_q, miss_run_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             locked_q, err_pulse_q, illegal_q;

    logic             pred_valid;
    logic [1:0]       pred;
    logic             is_ill, is_match;
    logic             err_ev, ill_ev, period_ev;

    // A previous code of 11 has no successor, so every following sample mismatches.
    always_comb begin
        pred_valid = 1'b1;
        pred       = 2'b00;
        unique case (prev_q)
            2'b00:   pred = 2'b01;
            2'b01:   pred = 2'b10;
            2'b10:   pred = 2'b00;
            default: pred_valid = 1'b0;
        endcase
    end

    assign is_ill   = (state_in == 2'b11);
    assign is_match = pred_valid && (state_in == pred);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_ev      = 1'b0;
        ill_ev      = 1'b0;
        period_ev   = 1'b0;
        if (en) begin
            prev_d = state_in;
            unique case (state_q)
                ST_HUNT: begin
                    if (is_ill) begin
                        ill_ev = 1'b1;
                    end else begin
                        state_d     = ST_SYNC;
                        match_run_d = 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (is_ill) begin
                        ill_ev  = 1'b1;
                        err_ev  = 1'b1;
                        state_d = ST_HUNT;
                    end else if (is_match) begin
                        match_run_d = match_run_q + 4'd1;
                        if (match_run_d == LOCK_THR) begin
                            state_d    = ST_LOCKED;
                            miss_run_d = 4'd0;
                        end
                    end else begin
                        err_ev      = 1'b1;
                        match_run_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (is_ill) begin
                        ill_ev  = 1'b1;
                        err_ev  = 1'b1;
                        state_d = ST_HUNT;
                    end else if (is_match) begin
                        miss_run_d = 4'd0;
                        period_ev  = (prev_q == 2'b10) && (state_in == 2'b00);
                    end else begin
                        err_ev     = 1'b1;
                        miss_run_d = miss_run_q + 4'd1;
                        if (miss_run_d == UNLOCK_THR) begin
                            state_d     = ST_SYNC;
                            match_run_d = 4'd0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment; error count saturates.
    always_comb begin
        period_d = period_q;
        err_d    = err_q;
        if (clr) begin
            period_d = '0;
            err_d    = '0;
        end else begin
            if (period_ev) begin
                period_d = period_q + CNT_W'(1);
            end
            if (err_ev && (err_q != {CNT_W{1'b1}})) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_HUNT;
            prev_q      <= 2'b00;
            match_run_q <= 4'd0;
            miss_run_q  <= 4'd0;
            period_q    <= '0;
            err_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            period_q    <= period_d;
            err_q       <= err_d;
            locked_q    <= (state_d == ST_LOCKED);
            err_pulse_q <= err_ev;
            illegal_q   <= ill_ev;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign illegal    = illegal_q;
    assign period_cnt = period_q;
    assign err_cnt    = err_q;

`ifdef SEQ_STATE_MONITOR_STUCK_EN
    logic [1:0] hold_q, hold_d;
    logic       stuck_q, stuck_d;

    // Hold count saturates at 3; a further identical sample raises the sticky flag.
    always_comb begin
        hold_d  = hold_q;
        stuck_d = stuck_q;
        if (en) begin
            if (state_in == prev_q) begin
                if (hold_q == 2'd3) begin
                    stuck_d = 1'b1;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end else begin
                hold_d = 2'd0;
            end
        end
        if (clr) begin
            stuck_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= 2'd0;
            stuck_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            stuck_q <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_seq_state_monitor.sv
// Directed, table-driven bench for seq_state_monitor (CNT_W=4) plus hand-written
// sequences for saturation, clear, enable gating and asynchronous reset.
module tb_seq_state_monitor;

    localparam int unsigned CNT_W = 4;
`ifdef SEQ_STATE_MONITOR_STUCK_EN
    localparam logic STUCK_ON = 1'b1;
`else
    localparam logic STUCK_ON = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic             en;
    logic [1:0]       state_in;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic             illegal;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             stuck;

    int n_cmp = 0;
    int n_bad = 0;

    seq_state_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_LEN   (3),
        .UNLOCK_LEN (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .state_in   (state_in),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .illegal    (illegal),
        .period_cnt (period_cnt),
        .err_cnt    (err_cnt),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] st;
        logic       clr;
        logic       l;
        logic       e;
        logic       i;
        logic [3:0] p;
        logic [3:0] c;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic e, input logic [1:0] s, input logic c);
        en       = e;
        state_in = s;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic l, input logic e, input logic i,
                             input logic [3:0] p, input logic [3:0] c);
        check({tag, ".locked"}, 32'(locked), 32'(l));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(e));
        check({tag, ".illegal"}, 32'(illegal), 32'(i));
        check({tag, ".period_cnt"}, 32'(period_cnt), 32'(p));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(c));
    endtask

    initial begin
        int exp_c;

        //                  en   st     clr   L     E     I     P     C
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}); // hunt -> sync
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}); // lock
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}); // period
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1}); // single miss
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1});
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1});
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd2}); // miss 1
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3}); // miss 2: unlock
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3});
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3}); // relock
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3});
        vq.push_back(vec_t'{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3}); // en=0
        vq.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3});
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3});
        vq.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd4}); // illegal locked
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4}); // -> sync
        vq.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd5}); // illegal sync
        vq.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5}); // illegal hunt
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5});
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5});
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5});
        vq.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}); // clr, en=0
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}); // clr beats err
        vq.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        vq.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}); // clr beats period
        vq.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});

        rstn     = 1'b0;
        en       = 1'b0;
        state_in = 2'b00;
        clr      = 1'b0;
        #3;
        check_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("reset.stuck", 32'(stuck), 32'd0);
        #9;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[k]) begin
            apply(vq[k].en, vq[k].st, vq[k].clr);
            check_all($sformatf("v%0d", k), vq[k].l, vq[k].e, vq[k].i, vq[k].p, vq[k].c);
            check($sformatf("v%0d.stuck", k), 32'(stuck), 32'd0);
        end

        // Two misses from LOCKED drop to SYNC, then a run of 00 saturates err_cnt.
        apply(1'b1, 2'b01, 1'b0);
        check_all("sat.m1", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
        apply(1'b1, 2'b01, 1'b0);
        check_all("sat.m2", 1'b0, 1'b1, 1'b0, 4'd0, 4'd2);
        exp_c = 2;
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, 2'b00, 1'b0);
            exp_c = (exp_c < 15) ? exp_c + 1 : 15;
            check($sformatf("sat%0d.err_pulse", k), 32'(err_pulse), 32'd1);
            check($sformatf("sat%0d.err_cnt", k), 32'(err_cnt), 32'(exp_c));
        end
        check("sat.locked", 32'(locked), 32'd0);
        check("sat.stuck", 32'(stuck), 32'(STUCK_ON));
        apply(1'b1, 2'b00, 1'b1);
        check_all("sat.clr", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("sat.clr.stuck", 32'(stuck), 32'd0);
        apply(1'b1, 2'b00, 1'b0);
        check_all("sat.after", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
        check("sat.after.stuck", 32'(stuck), 32'(STUCK_ON));
        apply(1'b0, 2'b00, 1'b1);
        check_all("sat.clr2", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("sat.clr2.stuck", 32'(stuck), 32'd0);

        // Relock from SYNC (prev=00) and complete one period.
        apply(1'b1, 2'b01, 1'b0);
        apply(1'b1, 2'b10, 1'b0);
        check("relock.pre", 32'(locked), 32'd0);
        apply(1'b1, 2'b00, 1'b0);
        check("relock.locked", 32'(locked), 32'd1);
        apply(1'b1, 2'b01, 1'b0);
        apply(1'b1, 2'b10, 1'b0);
        apply(1'b1, 2'b00, 1'b0);
        check_all("relock.period", 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);

        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 2'($urandom_range(0, 3)), 1'b0);
            check_all($sformatf("engate%0d", k), 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
        end

        // Mismatch, then reset asserted between clock edges.
        apply(1'b1, 2'b10, 1'b0);
        check_all("prerst", 1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
        #3;
        rstn = 1'b0;
        #1;
        check_all("arst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("arst.stuck", 32'(stuck), 32'd0);
        #2;
        rstn = 1'b1;
        apply(1'b1, 2'b01, 1'b0);
        apply(1'b1, 2'b10, 1'b0);
        check_all("postrst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
